// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int          MULDIV_ITER = 32;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MTHI  = 3'b000,
        OP_MTLO  = 3'b001,
        OP_MULT  = 3'b010,
        OP_MULTU = 3'b011,
        OP_DIV   = 3'b100,
        OP_DIVU  = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } muldiv_state_e;

    typedef enum logic {
        STEP_MUL,
        STEP_DIV
    } muldiv_step_e;

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the HI/LO sequencer.
// Latency: n/a (wires only).
// Backpressure: requester holds start until busy is observed low.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             start;
    muldiv_op_e       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration on a {upper, lower} accumulator.
// Latency: combinational.
// Backpressure: none.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_step_e       mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   diff;

    assign upper = acc[2*WIDTH-1:WIDTH];
    assign lower = acc[WIDTH-1:0];
    assign sum   = {1'b0, upper} + {1'b0, operand};
    assign part  = {upper, lower[WIDTH-1]};
    assign diff  = part - {1'b0, operand};

    // Divide: remainder < divisor keeps a successful subtract below 2^WIDTH, so bit WIDTH is the borrow.
    always_comb begin
        acc_next = acc;
        if (mode == STEP_MUL) begin
            acc_next = lower[0] ? {sum, lower[WIDTH-1:1]} : {1'b0, upper, lower[WIDTH-1:1]};
        end else begin
            acc_next = diff[WIDTH] ? {part[WIDTH-1:0], lower[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], lower[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Owns HI/LO; runs MULT/MULTU/DIV/DIVU as 32 iterations plus a sign-fix cycle, MTHI/MTLO in one edge.
// Latency: 33 busy cycles then done pulse; MTHI/MTLO/reserved done one cycle after accept.
// Backpressure: start ignored while busy; flush aborts without commit.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);

    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITER - 1);

    muldiv_state_e      state_q, state_d;
    muldiv_step_e       step_mode;
    logic [2*WIDTH-1:0] acc_q, step_acc, prod;
    logic [WIDTH-1:0]   opnd_q, rs_mag, rt_mag, quot, rem, hi_q, lo_q;
    logic [4:0]         cnt_q;
    logic               neg_res_q, neg_rem_q, div0_q, is_div_q;
    logic               busy_q, done_q;
    logic               accept, is_mul_op, is_div_op, is_signed, rs_neg, rt_neg;

    assign is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign accept    = bus.start && !bus.flush && (state_q == ST_IDLE);

    assign rs_neg = is_signed && bus.rs_val[WIDTH-1];
    assign rt_neg = is_signed && bus.rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

    assign step_mode = (state_q == ST_DIV) ? STEP_DIV : STEP_MUL;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (step_mode),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (step_acc)
    );

    // Divide by zero leaves the dividend magnitude as remainder; re-signing it restores the raw rs_val.
    assign prod = neg_res_q ? -acc_q : acc_q;
    assign quot = div0_q ? DIV0_QUOT
                         : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul_op) begin
                        state_d = ST_MUL;
                    end else if (is_div_op) begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            done_q <= 1'b0;
            if (accept) begin
                cnt_q     <= '0;
                neg_res_q <= rs_neg ^ rt_neg;
                neg_rem_q <= rs_neg;
                div0_q    <= is_div_op && (bus.rt_val == '0);
                is_div_q  <= is_div_op;
                if (is_div_op) begin
                    acc_q  <= {{WIDTH{1'b0}}, rs_mag};
                    opnd_q <= rt_mag;
                end else begin
                    acc_q  <= {{WIDTH{1'b0}}, rt_mag};
                    opnd_q <= rs_mag;
                end
                if (bus.op == OP_MTHI) begin
                    hi_q <= bus.rs_val;
                end
                if (bus.op == OP_MTLO) begin
                    lo_q <= bus.rs_val;
                end
                if (!is_mul_op && !is_div_op) begin
                    done_q <= 1'b1;
                end
            end else if ((state_q == ST_MUL) || (state_q == ST_DIV)) begin
                acc_q <= step_acc;
                cnt_q <= cnt_q + 1'b1;
            end else if ((state_q == ST_FIX) && !bus.flush) begin
                if (is_div_q) begin
                    hi_q <= rem;
                    lo_q <= quot;
                end else begin
                    hi_q <= prod[2*WIDTH-1:WIDTH];
                    lo_q <= prod[WIDTH-1:0];
                end
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer that owns the architectural HI/LO register pair and executes MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run as 32-iteration shift-add and restoring-divide loops. The block sits beside the execute stage. The pipeline stalls MFHI/MFLO and any new HI/LO op while `busy` is high, and may cancel an in-flight op with `flush`.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  issue strobe; accepted only when `busy`=0 and `flush`=0.
- `op`  in  3  000 MTHI, 001 MTLO, 010 MULT, 011 MULTU, 100 DIV, 101 DIVU, 11x reserved (accepted as no-op).
- `rs_val`  in  32  first operand (multiplicand/dividend; MTHI/MTLO source).
- `rt_val`  in  32  second operand (multiplier/divisor).
- `flush`  in  1  cancels the in-flight op.
- `busy`  out  1  op in progress.
- `done`  out  1  one-cycle pulse after HI/LO commit.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE.
- States and transitions:
  - IDLE → MUL on MULT/MULTU.
  - IDLE → DIV on DIV/DIVU.
  - IDLE stays IDLE for MTHI/MTLO/reserved.
  - MUL/DIV → FIX when the iteration counter reaches 31.
  - FIX → IDLE.
  - Any state → IDLE on `flush`.
- Accept: latches operand magnitudes, result sign flags and op; counter cleared.
  - Signed ops take the absolute value of each operand.
  - Unsigned ops use raw values.
- MTHI/MTLO: `hi` or `lo` is written from `rs_val` on the accepting edge. No busy cycles.
- MUL: one shift-add per cycle on a 64-bit accumulator.
- DIV: one restoring step per cycle, producing a 32-bit quotient and a 32-bit remainder.
- FIX stage:
  - Product: two's-complement negated if operand signs differ (signed only). `hi`/`lo` take the upper/lower halves.
  - Quotient: negated if signs differ. Remainder: takes the dividend's sign. `lo` = quotient, `hi` = remainder.
- Divide by zero (signed or unsigned): `lo`=0xFFFFFFFF, `hi`=`rs_val` as latched (raw, unsigned view). No exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. Falls out of the wrap arithmetic; no special case.
- `hi`/`lo` hold their old values until the FIX commit. Reads during `busy` return stale data; the pipeline must stall.
- `start` while `busy`=1 is ignored. The requester holds `start` until it observes `busy`=0.
- `flush` has priority over everything:
  - If busy: return to IDLE next edge, `hi`/`lo` unchanged, no `done`.
  - If idle: a coincident `start` is dropped.
  - Flush during the FIX cycle: the commit is suppressed.
- Reset mid-operation: immediate async clear, including `hi`/`lo`.

## Timing
- Start accepted at edge 0 → `busy` high cycles 1–33 (32 iterate + 1 FIX).
- `hi`/`lo` update at the end of cycle 33. `done` is high in cycle 34 and `busy` is low in cycle 34.
- A new `start` can be accepted in cycle 34 (back-to-back).
- MTHI/MTLO: register updated at edge 0. `done` high in cycle 1. `busy` never asserted.
- Reserved op: `done` high in cycle 1, no register change.
- All outputs are registered; no combinational path from input to output.

## Structure
- Package `muldiv_pkg` holds:
  - `muldiv_op_e` (3-bit op encoding).
  - `muldiv_state_e` (IDLE, MUL, DIV, FIX).
  - constant `MULDIV_ITER`=32.
  - div-by-zero quotient constant 0xFFFFFFFF.
- Sub-module `muldiv_step`: combinational single iteration.
  - Inputs: mode, accumulator, operand.
  - Output: next accumulator/quotient bits.
  - The sequencer keeps the counter, sign flags, FSM and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` cycles 1–33; `done` in cycle 34.
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then DIV −7 / 2 issued in cycle 34 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00000064. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → `hi`=0x1234, `lo`=0x5678; `done` each following cycle.
- MTHI 0xAAAA issued with `start` held while DIVU is busy → ignored until cycle 34, then accepted; `hi` ends 0xAAAA.
- MULTU with `flush` in cycle 10 → `busy` low in cycle 11, no `done`, `hi`/`lo` unchanged. Repeat with `reset` low in cycle 20 → all outputs 0 immediately.
